// File: rtl/axil_fifo_endpoint.sv
// axil_fifo_endpoint: AXI-Lite register window that bridges host accesses
// onto a TX and an RX 32-bit valid/ready stream with occupancy and ISR.

module axil_fifo_endpoint_fifo #(
    parameter int DEPTH_P = 16,
    parameter int CW_P    = $clog2(DEPTH_P) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [31:0]     data_i,
    input  logic            pop_i,
    output logic [31:0]     head_o,
    output logic [CW_P-1:0] cnt_o
);
    localparam int AW_L = $clog2(DEPTH_P);

    logic [31:0]     mem_q [DEPTH_P];
    logic [AW_L-1:0] wptr_q;
    logic [AW_L-1:0] rptr_q;
    logic [CW_P-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            if (push_i != pop_i)
                cnt_q <= push_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign head_o = mem_q[rptr_q];
    assign cnt_o  = cnt_q;
endmodule

module axil_fifo_endpoint #(
    parameter int FIFO_DEPTH_P = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        tx_v_o,
    output logic [31:0] tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_v_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_ready_o
);
    localparam int CW_L = $clog2(FIFO_DEPTH_P) + 1;
    localparam logic [CW_L-1:0] DEPTH_C = CW_L'(FIFO_DEPTH_P);
    localparam logic [9:0] IDX_TX  = 10'd0;
    localparam logic [9:0] IDX_VAC = 10'd1;
    localparam logic [9:0] IDX_RXD = 10'd2;
    localparam logic [9:0] IDX_RXO = 10'd3;
    localparam logic [9:0] IDX_ISR = 10'd4;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

    typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wr_state_e;

    wr_state_e   wstate_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [9:0]  awidx_q;
    logic [31:0] wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  isr_q;
    logic        rx_ready_q;

    logic            aw_hs, w_hs, ar_hs, wr_fire;
    logic [9:0]      wr_idx, rd_idx;
    logic [31:0]     wr_data, rd_data;
    logic [3:0]      wr_strb;
    logic [1:0]      wr_resp, rd_resp;
    logic            tx_push, tx_pop, tx_full, rx_push, rx_pop;
    logic            set_ovf, set_unf, set_strb;
    logic [2:0]      isr_clr;
    logic [31:0]     tx_head, rx_head;
    logic [CW_L-1:0] tx_cnt, rx_cnt, rx_cnt_nx;
    logic            addr_unused;

    assign addr_unused = ^{s_awaddr[31:12], s_awaddr[1:0],
                           s_araddr[31:12], s_araddr[1:0]};

    assign aw_hs   = s_awvalid & awready_q;
    assign w_hs    = s_wvalid & wready_q;
    assign ar_hs   = s_arvalid & arready_q;
    assign wr_idx  = aw_hs ? s_awaddr[11:2] : awidx_q;
    assign wr_data = w_hs ? s_wdata : wdata_q;
    assign wr_strb = w_hs ? s_wstrb : wstrb_q;
    // Second of the two address/data handshakes triggers the action.
    assign wr_fire = (aw_hs | (wstate_q == HAVE_AW))
                   & (w_hs | (wstate_q == HAVE_W));
    assign rd_idx  = s_araddr[11:2];
    assign tx_full = (tx_cnt == DEPTH_C);
    assign tx_v_o  = (tx_cnt != '0);
    assign tx_pop  = tx_v_o & tx_ready_i;
    assign rx_push = rx_v_i & rx_ready_q;

    always_comb begin
        tx_push  = 1'b0;
        set_ovf  = 1'b0;
        set_strb = 1'b0;
        isr_clr  = 3'b000;
        wr_resp  = OKAY;
        if (wr_fire) begin
            unique case (1'b1)
                wr_idx == IDX_TX: begin
                    if (wr_strb != 4'hF) begin
                        set_strb = 1'b1;
                        wr_resp  = SLVERR;
                    end else if (tx_full) begin
                        set_ovf = 1'b1;
                        wr_resp = SLVERR;
                    end else begin
                        tx_push = 1'b1;
                    end
                end
                wr_idx == IDX_VAC, wr_idx == IDX_RXD,
                wr_idx == IDX_RXO: wr_resp = OKAY;
                wr_idx == IDX_ISR: isr_clr = wr_data[2:0];
                default:           wr_resp = SLVERR;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        rd_resp = OKAY;
        rx_pop  = 1'b0;
        set_unf = 1'b0;
        unique case (1'b1)
            rd_idx == IDX_VAC: rd_data = 32'(DEPTH_C - tx_cnt);
            rd_idx == IDX_RXD: begin
                if (rx_cnt != '0) begin
                    rd_data = rx_head;
                    rx_pop  = ar_hs;
                end else begin
                    rd_resp = SLVERR;
                    set_unf = ar_hs;
                end
            end
            rd_idx == IDX_RXO: rd_data = 32'(rx_cnt);
            rd_idx == IDX_ISR: rd_data = {29'd0, isr_q};
            default:           rd_resp = SLVERR;
        endcase
    end

    assign rx_cnt_nx = rx_cnt + CW_L'(rx_push) - CW_L'(rx_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q  <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (aw_hs) awidx_q <= s_awaddr[11:2];
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            unique case (wstate_q)
                RESP: begin
                    if (s_bready) begin
                        wstate_q  <= IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: begin
                    if (wr_fire) begin
                        wstate_q  <= RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else if (aw_hs) begin
                        wstate_q  <= HAVE_AW;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                    end else if (w_hs) begin
                        wstate_q  <= HAVE_W;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                    end else if (wstate_q == IDLE) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            isr_q      <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                rvalid_q  <= 1'b1;
                arready_q <= 1'b0;
                rdata_q   <= rd_data;
                rresp_q   <= rd_resp;
            end else if (rvalid_q && s_rready) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end else begin
                arready_q <= ~rvalid_q;
            end
            // A new error event outranks a same-cycle W1C of that bit.
            isr_q      <= (isr_q & ~isr_clr) | {set_strb, set_unf, set_ovf};
            rx_ready_q <= (rx_cnt_nx != DEPTH_C);
        end
    end

    axil_fifo_endpoint_fifo #(.DEPTH_P(FIFO_DEPTH_P), .CW_P(CW_L)) u_tx (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .push_i (tx_push),
        .data_i (wr_data),
        .pop_i  (tx_pop),
        .head_o (tx_head),
        .cnt_o  (tx_cnt)
    );

    axil_fifo_endpoint_fifo #(.DEPTH_P(FIFO_DEPTH_P), .CW_P(CW_L)) u_rx (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .push_i (rx_push),
        .data_i (rx_data_i),
        .pop_i  (rx_pop),
        .head_o (rx_head),
        .cnt_o  (rx_cnt)
    );

    assign s_awready  = awready_q;
    assign s_wready   = wready_q;
    assign s_bvalid   = bvalid_q;
    assign s_bresp    = bresp_q;
    assign s_arready  = arready_q;
    assign s_rvalid   = rvalid_q;
    assign s_rdata    = rdata_q;
    assign s_rresp    = rresp_q;
    assign tx_data_o  = tx_v_o ? tx_head : '0;
    assign rx_ready_o = rx_ready_q;
endmodule

// File: doc/axil_fifo_endpoint.md
Name: axil_fifo_endpoint

Overview:
- AXI-Lite slave endpoint that sits on one master slot of the 1-to-4 AXI-Lite crossbar, which decodes a 4 KB (12-bit) window per slot.
- Converts host register accesses into two 32-bit valid/ready streams:
  - writes to TX_DATA push into a TX FIFO that drains toward the fabric;
  - the fabric fills an RX FIFO that the host pops by reading RX_DATA.
- Also exposes occupancy counts and sticky error flags.

Parameters:
- FIFO_DEPTH_P, 16, entries per FIFO; must be a power of 2 and at least 2. Counters are $clog2(FIFO_DEPTH_P)+1 bits wide.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_awaddr  in  32  write address; only [11:0] decoded
- s_awvalid  in  1 / s_awready  out  1
- s_wdata  in  32 / s_wstrb  in  4 / s_wvalid  in  1 / s_wready  out  1
- s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1
- s_araddr  in  32  read address; only [11:0] decoded
- s_arvalid  in  1 / s_arready  out  1
- s_rdata  out  32 / s_rresp  out  2 / s_rvalid  out  1 / s_rready  in  1
- tx_v_o  out  1 / tx_data_o  out  32 / tx_ready_i  in  1  TX stream toward fabric
- rx_v_i  in  1 / rx_data_i  in  32 / rx_ready_o  out  1  RX stream from fabric

Behaviour:
- Reset (aresetn low, async) clears all outputs to 0, empties both FIFOs, clears ISR. Ready outputs rise on the first aclk edge after deassertion.
- Register map, addr[11:2] word index; addr[1:0] ignored:
  - 0x000 TX_DATA, W: push wdata.
  - 0x004 TX_VACANCY, R: FIFO_DEPTH_P minus TX count.
  - 0x008 RX_DATA, R: pop.
  - 0x00C RX_OCCUPANCY, R: RX count.
  - 0x010 ISR, R / W1C: bit0 tx_overflow, bit1 rx_underflow, bit2 bad_strobe.
  - Any other address: write ignored, read data 0, resp SLVERR (2'b10).
- Write channel FSM, states IDLE, HAVE_AW, HAVE_W, RESP:
  - s_awready = state in {IDLE, HAVE_W}; s_wready = state in {IDLE, HAVE_AW}.
  - AW and W may handshake in the same cycle or in either order; addr/data/strb are latched at their handshake.
  - On the edge that completes the second handshake: perform the action, then s_bvalid=1 and state=RESP.
  - In RESP, hold bresp until s_bready; then return to IDLE. One outstanding write.
- TX_DATA write outcomes:
  - wstrb != 4'hF: no push, SLVERR, set ISR bit2.
  - TX full at the action edge: no push, SLVERR, set bit0. A same-cycle drain does not rescue the write.
  - Otherwise: push, OKAY.
- Writes to read-only registers (0x004, 0x008, 0x00C): OKAY, no effect.
- Read channel:
  - s_arready = ~s_rvalid.
  - On the AR handshake edge: s_rdata/s_rresp are registered and s_rvalid=1 the next cycle, i.e. 1-cycle latency. They are held stable until s_rready.
  - One outstanding read. Back-to-back read throughput is one per 2 cycles when rready is tied high.
- RX_DATA read:
  - RX non-empty at the AR edge: return the head, pop, OKAY.
  - RX empty: rdata 0, SLVERR, set bit1. A same-cycle rx fill does not rescue the read.
- TX stream:
  - tx_v_o = TX non-empty; tx_data_o = head, stable while tx_v_o && !tx_ready_i.
  - Data is visible on tx_data_o the cycle after the push edge.
- RX stream: rx_ready_o = RX not full; the push occurs on rx_v_i && rx_ready_o.
- Counters: simultaneous push and pop leaves the count unchanged. Pointers wrap mod FIFO_DEPTH_P; full is count==FIFO_DEPTH_P.
- ISR:
  - A set event and a W1C clear of the same bit in the same cycle: set wins.
  - An ISR read returns the pre-clear value.
- Reset mid-transaction drops any in-flight AW/W/B/AR/R and both FIFO contents. No response is issued after reset.

Test Plan:
- Post-reset read of 0x004 then 0x00C -> rdata 16 and 0, both OKAY. Read 0x008 -> rdata 0, SLVERR, ISR reads 0x2; write 0x2 to 0x010, re-read ISR -> 0x0.
- W handshake 3 cycles before AW, wdata 0xA5A5_0001 to 0x000, tx_ready_i=0 -> bvalid exactly 1 cycle after AW handshake, OKAY. tx_v_o=1 with tx_data_o=0xA5A5_0001; 0x004 reads 15.
- 17 writes to 0x000 with tx_ready_i=0 -> first 16 OKAY, 17th SLVERR, ISR bit0 set. Then tx_ready_i=1 -> 16 words emitted in order, no gaps.
- Drive rx_v_i with 0x1..0x10 -> rx_ready_o drops after 16 accepted. 16 reads of 0x008 with rready held low 2 cycles each -> rdata 0x1..0x10 in order, stable while stalled.
- Write 0x000 with wstrb=4'h3 -> SLVERR, no push, ISR bit2 set. Access 0x7FC -> write OKAY-less SLVERR; read 0 with SLVERR.
- Assert aresetn low while bvalid is pending and 5 entries are in TX -> bvalid=0, tx_v_o=0 immediately (async). After release, 0x004 reads 16.
